// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS control unit
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        R_ALU, I_ALU, LOAD, STORE, BRANCH, JUMP, JR, ILLEGAL
    } instr_class_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [3:0] ALU_NONE    = 4'd0;
    localparam logic [3:0] ALU_ADD     = 4'd1;
    localparam logic [3:0] ALU_AND     = 4'd2;
    localparam logic [3:0] ALU_NOR     = 4'd3;
    localparam logic [3:0] ALU_OR      = 4'd4;
    localparam logic [3:0] ALU_SLT     = 4'd5;
    localparam logic [3:0] ALU_SUB_CMP = 4'd6;
    localparam logic [3:0] ALU_SUB     = 4'd7;
    localparam logic [3:0] ALU_SUBU    = 4'd8;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_RS     = 2'd3;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_IMEM    = 2'd2;
    localparam logic [1:0] CAUSE_DMEM    = 2'd3;

endpackage

// File: rtl/mips_instr_decoder.sv
// rtl/mips_instr_decoder.sv - opcode/funct to instruction class and datapath controls
module mips_instr_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_t iclass,
    output logic [3:0]   alu_op,
    output logic         alu_src,
    output logic         reg_dst,
    output logic         is_bne
);

    // Pure lookup; unknown encodings fall through to ILLEGAL
    always_comb begin
        iclass  = ILLEGAL;
        alu_op  = ALU_NONE;
        alu_src = 1'b0;
        reg_dst = 1'b0;
        is_bne  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                reg_dst = 1'b1;
                iclass  = R_ALU;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_SUBU: alu_op = ALU_SUBU;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_JR:   iclass = JR;
                    default: iclass = ILLEGAL;
                endcase
            end
            OP_J:    iclass = JUMP;
            OP_BEQ:  begin iclass = BRANCH; alu_op = ALU_SUB_CMP; end
            OP_BNE:  begin iclass = BRANCH; alu_op = ALU_SUB_CMP; is_bne = 1'b1; end
            OP_ADDI: begin iclass = I_ALU; alu_op = ALU_ADD; alu_src = 1'b1; end
            OP_SLTI: begin iclass = I_ALU; alu_op = ALU_SLT; alu_src = 1'b1; end
            OP_ANDI: begin iclass = I_ALU; alu_op = ALU_AND; alu_src = 1'b1; end
            OP_ORI:  begin iclass = I_ALU; alu_op = ALU_OR;  alu_src = 1'b1; end
            OP_LW:   begin iclass = LOAD;  alu_op = ALU_ADD; alu_src = 1'b1; end
            OP_SW:   begin iclass = STORE; alu_op = ALU_ADD; alu_src = 1'b1; end
            default: iclass = ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - multi-cycle FSM control with memory handshakes and trap
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int ALU_OP_W = 4,
    parameter int WAIT_MAX = 16,
    parameter int WAIT_W   = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                alu_zero,
    output logic                imem_req,
    input  logic                imem_ack,
    output logic                dmem_req,
    output logic                dmem_we,
    input  logic                dmem_ack,
    output logic                ir_load,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                alu_src,
    output logic                mem_to_reg,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [2:0]          state
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = (WAIT_MAX == 0) ? '0 : WAIT_W'(WAIT_MAX - 1);

    state_t            state_q, state_d;
    logic [1:0]        cause_q, cause_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout;

    instr_class_t      dec_class;
    logic [3:0]        dec_alu_op;
    logic              dec_alu_src, dec_reg_dst, dec_is_bne;

    mips_instr_decoder u_decoder (
        .opcode  (opcode),
        .funct   (funct),
        .iclass  (dec_class),
        .alu_op  (dec_alu_op),
        .alu_src (dec_alu_src),
        .reg_dst (dec_reg_dst),
        .is_bne  (dec_is_bne)
    );

    // Last permitted wait cycle; a zero WAIT_MAX disables the check entirely
    assign timeout = (WAIT_MAX != 0) && (wait_cnt == WAIT_LAST);

    // State, sticky cause and wait counter; counter restarts on every state change
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            cause_q  <= CAUSE_NONE;
            wait_cnt <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (state_d != state_q)
                wait_cnt <= '0;
            else if (imem_req || dmem_req)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Next-state and output decode; reset forces every output low in the same cycle
    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_load    = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_PLUS4;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        alu_op     = '0;
        trap       = 1'b0;
        trap_cause = CAUSE_NONE;
        state      = reset ? 3'd0 : state_q;
        if (reset) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_load  = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = PC_PLUS4;
                        state_d  = S_DECODE;
                    end else if (timeout) begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_IMEM;
                    end
                end
                S_DECODE: begin
                    if (dec_class == ILLEGAL) begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_op  = ALU_OP_W'(dec_alu_op);
                    alu_src = dec_alu_src;
                    case (dec_class)
                        JUMP:        begin pc_write = 1'b1; pc_src = PC_JUMP; state_d = S_FETCH; end
                        JR:          begin pc_write = 1'b1; pc_src = PC_RS;   state_d = S_FETCH; end
                        BRANCH: begin
                            pc_src   = PC_BRANCH;
                            pc_write = dec_is_bne ? !alu_zero : alu_zero;
                            state_d  = S_FETCH;
                        end
                        LOAD, STORE: state_d = S_MEM;
                        default:     state_d = S_WB;
                    endcase
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (dec_class == STORE);
                    alu_op   = ALU_OP_W'(ALU_ADD);
                    alu_src  = 1'b1;
                    if (dmem_ack) begin
                        state_d = (dec_class == STORE) ? S_FETCH : S_WB;
                    end else if (timeout) begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_DMEM;
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = dec_reg_dst;
                    mem_to_reg = (dec_class == LOAD);
                    alu_op     = ALU_OP_W'(dec_alu_op);
                    alu_src    = dec_alu_src;
                    state_d    = S_FETCH;
                end
                S_TRAP: begin
                    trap       = 1'b1;
                    trap_cause = cause_q;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule
